rs: RTL

Reservation station for arithmetic, branch and jump instructions, directly downstream of the reorder buffer. Each cycle it accepts at most one renamed instruction from the ROB, holds it until both source operands are valid, and issues at most one ready instruction per cycle to the execute unit. It snoops the EX and LSB result broadcasts to wake up waiting operands and flushes completely on misprediction.

---
 rtl/rs_pkg.sv | 49 ++++
 rtl/rs_sel.sv | 20 ++
 rtl/rs.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared widths, entry layout and the operand snoop helper for the reservation station.
// The RS_*_DEF values are the default geometry for the rs parameters.
package rs_pkg;
  localparam int REG_DAT_W       = 32;
  localparam int ROB_ADD_W       = 5;
  localparam int INS_OP_W        = 6;
  localparam int RS_S_DEF        = 16;
  localparam int RS_ADD_W_DEF    = 4;
  localparam int FULL_MARGIN_DEF = 2;

  typedef struct packed {
    logic [ROB_ADD_W-1:0] q;
    logic [REG_DAT_W-1:0] v;
  } opnd_t;

  typedef struct packed {
    logic [INS_OP_W-1:0]  op;
    logic [31:0]          pc;
    logic [31:0]          imm;
    opnd_t                s1;
    opnd_t                s2;
    logic [ROB_ADD_W-1:0] qd;
  } entry_t;

  // Tag 0 means the value is already present, so it never matches a broadcast.
  // EX wins over LSB when both carry the same tag.
  function automatic opnd_t snoop(
    input logic [ROB_ADD_W-1:0] q,
    input logic [REG_DAT_W-1:0] v,
    input logic                 ex_en,
    input logic [ROB_ADD_W-1:0] ex_qd,
    input logic [REG_DAT_W-1:0] ex_vd,
    input logic                 lsb_en,
    input logic [ROB_ADD_W-1:0] lsb_qd,
    input logic [REG_DAT_W-1:0] lsb_vd
  );
    opnd_t r;
    r.q = q;
    r.v = v;
    if (q != '0 && ex_en && q == ex_qd) begin
      r.q = '0;
      r.v = ex_vd;
    end else if (q != '0 && lsb_en && q == lsb_qd) begin
      r.q = '0;
      r.v = lsb_vd;
    end
    return r;
  endfunction
endpackage

// File: rtl/rs_sel.sv
// Lowest-index priority encoder: returns the index of the lowest set request bit.
module rs_sel #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         vld
);
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rs.sv
// Reservation station: allocates one renamed instruction per cycle, wakes operands
// from the EX/LSB broadcasts and issues the lowest-index ready entry each cycle.
module rs
  import rs_pkg::*;
#(
  parameter int RS_S        = RS_S_DEF,
  parameter int RS_ADD_W    = RS_ADD_W_DEF,
  parameter int FULL_MARGIN = FULL_MARGIN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iMp,
  input  logic                 iROB_En,
  input  logic [INS_OP_W-1:0]  iROB_Op,
  input  logic [31:0]          iROB_Pc,
  input  logic [31:0]          iROB_Imm,
  input  logic [ROB_ADD_W-1:0] iROB_Qs1,
  input  logic [ROB_ADD_W-1:0] iROB_Qs2,
  input  logic [REG_DAT_W-1:0] iROB_Vs1,
  input  logic [REG_DAT_W-1:0] iROB_Vs2,
  input  logic [ROB_ADD_W-1:0] iROB_Qd,
  input  logic                 iEX_En,
  input  logic [ROB_ADD_W-1:0] iEX_Qd,
  input  logic [REG_DAT_W-1:0] iEX_Vd,
  input  logic                 iLSB_En,
  input  logic [ROB_ADD_W-1:0] iLSB_Qd,
  input  logic [REG_DAT_W-1:0] iLSB_Vd,
  output logic                 oEX_En,
  output logic [INS_OP_W-1:0]  oEX_Op,
  output logic [31:0]          oEX_Pc,
  output logic [31:0]          oEX_Imm,
  output logic [REG_DAT_W-1:0] oEX_Vs1,
  output logic [REG_DAT_W-1:0] oEX_Vs2,
  output logic [ROB_ADD_W-1:0] oEX_Qd,
  output logic                 oFull
);
  logic [RS_S-1:0]     busy;
  logic [RS_S-1:0]     ready;
  entry_t              ent [RS_S];
  entry_t              new_ent;
  logic [RS_ADD_W-1:0] free_idx;
  logic [RS_ADD_W-1:0] rdy_idx;
  logic                free_vld;
  logic                rdy_vld;
  logic                alloc_go;
  logic [RS_ADD_W:0]   free_cnt;

  rs_sel #(.N(RS_S), .W(RS_ADD_W)) u_free_sel (
    .req (~busy),
    .idx (free_idx),
    .vld (free_vld)
  );

  rs_sel #(.N(RS_S), .W(RS_ADD_W)) u_rdy_sel (
    .req (ready),
    .idx (rdy_idx),
    .vld (rdy_vld)
  );

  always_comb begin
    for (int i = 0; i < RS_S; i++) begin
      ready[i] = busy[i] && (ent[i].s1.q == '0) && (ent[i].s2.q == '0);
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < RS_S; i++) begin
      if (!busy[i]) free_cnt = free_cnt + (RS_ADD_W+1)'(1);
    end
  end

  assign oFull    = (free_cnt <= (RS_ADD_W+1)'(FULL_MARGIN));
  // A request with no free slot is silently dropped.
  assign alloc_go = iROB_En && free_vld;

  always_comb begin
    new_ent    = '0;
    new_ent.op  = iROB_Op;
    new_ent.pc  = iROB_Pc;
    new_ent.imm = iROB_Imm;
    new_ent.qd  = iROB_Qd;
    new_ent.s1  = snoop(iROB_Qs1, iROB_Vs1, iEX_En, iEX_Qd, iEX_Vd,
                        iLSB_En, iLSB_Qd, iLSB_Vd);
    new_ent.s2  = snoop(iROB_Qs2, iROB_Vs2, iEX_En, iEX_Qd, iEX_Vd,
                        iLSB_En, iLSB_Qd, iLSB_Vd);
  end

  // Entry payload: written on allocation, operands refreshed by wakeup; validity lives in busy.
  always_ff @(posedge clk) begin
    if (en && !iMp) begin
      for (int i = 0; i < RS_S; i++) begin
        if (alloc_go && free_idx == RS_ADD_W'(i)) begin
          ent[i] <= new_ent;
        end else if (busy[i]) begin
          ent[i].s1 <= snoop(ent[i].s1.q, ent[i].s1.v, iEX_En, iEX_Qd, iEX_Vd,
                             iLSB_En, iLSB_Qd, iLSB_Vd);
          ent[i].s2 <= snoop(ent[i].s2.q, ent[i].s2.v, iEX_En, iEX_Qd, iEX_Vd,
                             iLSB_En, iLSB_Qd, iLSB_Vd);
        end
      end
    end
  end

  // Issue stage: selected entry registered onto oEX_*, its slot freed at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      oEX_En  <= 1'b0;
      oEX_Op  <= '0;
      oEX_Pc  <= '0;
      oEX_Imm <= '0;
      oEX_Vs1 <= '0;
      oEX_Vs2 <= '0;
      oEX_Qd  <= '0;
    end else if (iMp) begin
      busy   <= '0;
      oEX_En <= 1'b0;
    end else if (en) begin
      oEX_En <= rdy_vld;
      if (rdy_vld) begin
        busy[rdy_idx] <= 1'b0;
        oEX_Op        <= ent[rdy_idx].op;
        oEX_Pc        <= ent[rdy_idx].pc;
        oEX_Imm       <= ent[rdy_idx].imm;
        oEX_Vs1       <= ent[rdy_idx].s1.v;
        oEX_Vs2       <= ent[rdy_idx].s2.v;
        oEX_Qd        <= ent[rdy_idx].qd;
      end
      if (alloc_go) busy[free_idx] <= 1'b1;
    end else begin
      oEX_En <= 1'b0;
    end
  end
endmodule
